// File: rtl/mem_pkg.sv
// Shared types and constants for the pipelined single-port memory.
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned PAR_MAX_W  = 64;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Even-parity bit for a word; zero-extension does not change the result.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line: RD_LAT-1 register stages carrying {valid, data, par_err}.
// Data only advances alongside a valid token, so the output holds its last read value.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_perr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr
);

  localparam int unsigned STAGES = RD_LAT - 1;

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_perr  = in_perr;
    end else begin : g_regs
      logic [STAGES-1:0]             valid_q, valid_d;
      logic [STAGES-1:0]             perr_q, perr_d;
      logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;

      // Index 0 of each chain is the pipe input; index i+1 is stage i.
      logic [STAGES:0]               v_chain;
      logic [STAGES:0]               p_chain;
      logic [STAGES:0][DATA_W-1:0]   d_chain;

      assign v_chain = {valid_q, in_valid};
      assign p_chain = {perr_q, in_perr};
      assign d_chain = {data_q, in_data};

      always_comb begin
        valid_d = '0;
        perr_d  = perr_q;
        data_d  = data_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
          valid_d[i] = v_chain[i];
          if (v_chain[i]) begin
            data_d[i] = d_chain[i];
            perr_d[i] = p_chain[i];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q <= '0;
          perr_q  <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          perr_q  <= perr_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
      assign out_perr  = perr_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mem_pipelined.sv
// Parametrised single-port synchronous RAM with ready handshake, pipelined reads
// and a post-reset clear sweep. Optional parity storage/check under MEM_PARITY_EN.
module mem_pipelined
  import mem_pkg::*;
#(
  parameter int unsigned        DATA_W         = DATA_W_DEF,
  parameter int unsigned        ADDR_W         = ADDR_W_DEF,
  parameter int unsigned        RD_LAT         = 1,
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VAL       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              par_inject,
  output logic              rd_par_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [MEM_W-1:0]  mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              s0_valid_q, s0_valid_d;
  logic [DATA_W-1:0] s0_data_q, s0_data_d;
  logic              s0_perr_q, s0_perr_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  clear_word;
  logic [MEM_W-1:0]  wr_word;
  logic              rd_perr;
  logic              accept_wr, accept_rd;

  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_perr;

  assign rd_word = mem[addr];

`ifdef MEM_PARITY_EN
  assign clear_word = {even_parity(PAR_MAX_W'(INIT_VAL)), INIT_VAL};
  assign wr_word    = {even_parity(PAR_MAX_W'(wr_data)) ^ par_inject, wr_data};
  assign rd_perr    = even_parity(PAR_MAX_W'(rd_word[DATA_W-1:0])) ^ rd_word[DATA_W];
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject;
  assign clear_word = INIT_VAL;
  assign wr_word    = wr_data;
  assign rd_perr    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = wr_word;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    s0_valid_d = 1'b0;
    s0_data_d  = s0_data_q;
    s0_perr_d  = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = clear_word;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Write wins over a simultaneous read request.
        accept_wr = ready_q & wr_en;
        accept_rd = ready_q & rd_en & ~wr_en;
      end
    endcase

    if (accept_wr) mem_we = 1'b1;

    if (accept_rd) begin
      s0_valid_d = 1'b1;
      s0_data_d  = rd_word[DATA_W-1:0];
      s0_perr_d  = rd_perr;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_perr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s0_perr_q  <= s0_perr_d;
    end
  end

  // Array is never reset; writes are simply suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s0_valid_q),
    .in_data   (s0_data_q),
    .in_perr   (s0_perr_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_perr  (pipe_perr)
  );

  assign ready      = ready_q;
  assign rd_valid   = pipe_valid;
  assign rd_data    = pipe_data;
  assign rd_par_err = pipe_valid & pipe_perr;

endmodule

// File: tb/tb_mem_pipelined.sv
// Scoreboard bench for mem_pipelined: reference memory model plus expected-read queue.
module tb_mem_pipelined;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] INIT_VAL = 8'h00;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              par_inject = 1'b0;
  logic              ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_par_err;

  always #5 clk = ~clk;

  mem_pipelined #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .RD_LAT         (RD_LAT),
    .CLEAR_ON_RESET (1'b1),
    .INIT_VAL       (INIT_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .ready      (ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .par_inject (par_inject),
    .rd_par_err (rd_par_err)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    int                cyc;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_par [DEPTH];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  logic              rst_seen = 1'b0;
  bit                run_mon = 1'b0;
  logic [DATA_W-1:0] last_data = '0;
  bit                exp_v;
  exp_t              e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h time=%0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Monitor: compares every cycle's output against the head of the expected queue.
  always @(negedge clk) begin
    if (run_mon) begin
      if (!rst_seen) begin
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_par_err", 32'(rd_par_err), 32'(0));
        last_data = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc + int'(RD_LAT) - 1 < cyc) begin
          void'(exp_q.pop_front());
          chk("rd_missing", 32'(0), 32'(1));
        end
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc + int'(RD_LAT) - 1 == cyc);
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        if (exp_v) begin
          e = exp_q.pop_front();
          if (rd_valid) begin
            chk("rd_data", 32'(rd_data), 32'(e.data));
            chk("rd_par_err", 32'(rd_par_err), 32'(e.perr));
          end
        end else begin
          chk("rd_data_hold", 32'(rd_data), 32'(last_data));
          chk("par_err_idle", 32'(rd_par_err), 32'(0));
        end
        if (rd_valid) last_data = rd_data;
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = INIT_VAL;
      ref_par[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    par_inject = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one request at the next edge; caller is always 1 time unit after an edge.
  task automatic issue(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit inj);
    int n;
    n = 0;
    if (!ready) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      while (!ready && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!ready) begin
        chk("ready_timeout", 32'(0), 32'(1));
        return;
      end
    end
    addr = a;
    wr_data = d;
    wr_en = wr;
    rd_en = rd;
    par_inject = inj;
    @(posedge clk);
    #1;
    if (wr) begin
      ref_mem[a] = d;
`ifdef MEM_PARITY_EN
      ref_par[a] = inj;
`else
      ref_par[a] = 1'b0;
`endif
    end else if (rd) begin
      exp_q.push_back(exp_t'{data: ref_mem[a], perr: ref_par[a], cyc: cyc});
    end
  endtask

  // Counts ready=0 samples from the reset edge until ready rises; optionally pokes requests.
  task automatic wait_sweep(input string name, input bit poke);
    int n;
    n = 0;
    while (!ready && n < 4 * int'(DEPTH)) begin
      if (poke) begin
        addr = 5'd3;
        wr_data = 8'hFF;
        wr_en = (n < int'(DEPTH) / 2);
        rd_en = !(n < int'(DEPTH) / 2);
      end
      n++;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit                w, r, inj;
    int                op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_mon = 1'b1;
    chk("reset_ready", 32'(ready), 32'(0));
    chk("reset_rd_valid", 32'(rd_valid), 32'(0));
    chk("reset_rd_data", 32'(rd_data), 32'(0));
    chk("reset_rd_par_err", 32'(rd_par_err), 32'(0));
    model_reset();
    rst = 1'b1;
    wait_sweep("clear_cycles", 1'b1);

    for (int i = 0; i < int'(DEPTH); i++) issue(1'b0, 1'b1, ADDR_W'(i), '0, 1'b0);
    idle(2);

    issue(1'b1, 1'b0, 5'h10, 8'hA5, 1'b0);
    issue(1'b0, 1'b1, 5'h10, '0, 1'b0);
    idle(1);

    issue(1'b1, 1'b0, 5'h01, 8'h11, 1'b0);
    issue(1'b1, 1'b0, 5'h02, 8'h22, 1'b0);
    issue(1'b1, 1'b0, 5'h03, 8'h33, 1'b0);
    issue(1'b0, 1'b1, 5'h01, '0, 1'b0);
    issue(1'b0, 1'b1, 5'h02, '0, 1'b0);
    issue(1'b0, 1'b1, 5'h03, '0, 1'b0);
    idle(2);

    issue(1'b1, 1'b1, 5'h05, 8'h7E, 1'b0);
    issue(1'b0, 1'b1, 5'h05, '0, 1'b0);
    idle(4);

`ifdef MEM_PARITY_EN
    issue(1'b1, 1'b0, 5'h07, 8'h3C, 1'b1);
    issue(1'b0, 1'b1, 5'h07, '0, 1'b0);
    issue(1'b1, 1'b0, 5'h07, 8'h3C, 1'b0);
    issue(1'b0, 1'b1, 5'h07, '0, 1'b0);
    idle(4);
`endif

    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 3));
      a   = ADDR_W'($urandom);
      d   = DATA_W'($urandom);
      inj = ($urandom_range(0, 7) == 0);
      w   = (op == 1) || (op == 3);
      r   = (op == 2) || (op == 3);
      if (op == 0) idle(1);
      else issue(w, r, a, d, inj);
    end
    idle(RD_LAT + 2);

    // Two reads in flight when a one-cycle reset lands; neither may return.
    issue(1'b1, 1'b0, 5'h09, 8'hAB, 1'b0);
    issue(1'b0, 1'b1, 5'h09, '0, 1'b0);
    issue(1'b0, 1'b1, 5'h09, '0, 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    chk("midrst_ready", 32'(ready), 32'(0));
    wait_sweep("resweep_cycles", 1'b0);
    issue(1'b0, 1'b1, 5'h09, '0, 1'b0);
    issue(1'b0, 1'b1, 5'h00, '0, 1'b0);
    issue(1'b0, 1'b1, 5'h1F, '0, 1'b0);

    idle(RD_LAT + 4);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
